float_normalize: RTL

FLOAT_NORMALIZE -- requirements
Module: float_normalize

---
 rtl/float_normalize_if.sv | 26 ++
 rtl/float_normalize.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/float_normalize_if.sv
// Handshake bundle between the magnitude ALU (upstream), the normalizer and
// the result consumer (downstream). The normalizer uses the slave view; the
// environment that feeds it and drains it uses the master view.
interface float_normalize_if;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] sum_mant;
    logic        c_out;
    logic [7:0]  exp_in;
    logic        sign_in;
    logic [31:0] result;
    logic        out_valid;
    logic        out_ready;
    logic        overflow;
    logic        underflow;

    modport master (
        output in_valid, sum_mant, c_out, exp_in, sign_in, out_ready,
        input  in_ready, result, out_valid, overflow, underflow
    );

    modport slave (
        input  in_valid, sum_mant, c_out, exp_in, sign_in, out_ready,
        output in_ready, result, out_valid, overflow, underflow
    );
endinterface

// File: rtl/float_normalize.sv
// Post-add normalizer for IEEE-754 single precision.
// Takes a raw 24-bit significand sum (hidden bit at [23]) plus the ALU
// carry-out, and produces a packed single with truncation rounding.
// A carry is absorbed by one right shift; leading zeros are removed one
// bit per cycle. Exponent overflow saturates to infinity, exponent
// underflow flushes to signed zero (no denormals are produced).
module float_normalize (
    input  logic              clk,
    input  logic              rst,
    float_normalize_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        DONE
    } state_t;

    state_t      state_q, state_d;

    // Working registers for the operation in flight. The exponent carries a
    // ninth bit so the +1 after a carry can be compared against 255 without
    // wrapping.
    logic [23:0] mant_q,   mant_d;
    logic [8:0]  exp_q,    exp_d;
    logic        sign_q,   sign_d;
    logic        carry_q,  carry_d;

    // Output registers, held stable through the whole DONE state.
    logic [31:0] result_q, result_d;
    logic        ovf_q,    ovf_d;
    logic        unf_q,    unf_d;

    // Carry-absorbing right shift: the carry becomes the new hidden bit and
    // the old LSB is dropped (truncation).
    logic [23:0] mant_carry;
    logic [8:0]  exp_inc;

    assign mant_carry = {1'b1, mant_q[23:1]};
    assign exp_inc    = exp_q + 9'd1;

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;

    // Next-state and datapath decode; one normalization decision per cycle.
    always_comb begin
        // NOTE: every signal driven here gets a hold value first, so no path
        // through the case/if tree can leave one unassigned and infer a latch.
        state_d  = state_q;
        mant_d   = mant_q;
        exp_d    = exp_q;
        sign_d   = sign_q;
        carry_d  = carry_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    mant_d  = bus.sum_mant;
                    exp_d   = {1'b0, bus.exp_in};
                    sign_d  = bus.sign_in;
                    carry_d = bus.c_out;
                    state_d = NORM;
                end
            end

            NORM: begin
                ovf_d = 1'b0;
                unf_d = 1'b0;
                // The exponent only ever decreases while in NORM, so an
                // all-ones exponent here can only be the captured operand.
                if (exp_q == 9'h0FF) begin
                    result_d = {sign_q, 8'hFF, 23'h0};
                    ovf_d    = 1'b1;
                    state_d  = DONE;
                end else if (carry_q) begin
                    mant_d  = mant_carry;
                    exp_d   = exp_inc;
                    state_d = DONE;
                    if (exp_inc >= 9'd255) begin
                        result_d = {sign_q, 8'hFF, 23'h0};
                        ovf_d    = 1'b1;
                    end else begin
                        result_d = {sign_q, exp_inc[7:0], mant_carry[22:0]};
                    end
                end else if (mant_q == 24'h0) begin
                    result_d = {sign_q, 31'h0};
                    state_d  = DONE;
                end else if (exp_q == 9'h000) begin
                    result_d = {sign_q, 31'h0};
                    unf_d    = 1'b1;
                    state_d  = DONE;
                end else if (mant_q[23]) begin
                    result_d = {sign_q, exp_q[7:0], mant_q[22:0]};
                    state_d  = DONE;
                end else if (exp_q == 9'h001) begin
                    // One more left shift would need exponent 0: flush.
                    result_d = {sign_q, 31'h0};
                    unf_d    = 1'b1;
                    state_d  = DONE;
                end else begin
                    // A nonzero 24-bit significand reaches bit 23 within 23
                    // of these shifts, which bounds the NORM dwell time.
                    mant_d = {mant_q[22:0], 1'b0};
                    exp_d  = exp_q - 9'd1;
                end
            end

            DONE: begin
                if (bus.out_ready) begin
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, working and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: the working registers are plain flops, not a memory array, so
        // clearing them on reset is cheap and makes an abandoned operation
        // leave no trace.
        if (rst) begin
            state_q  <= IDLE;
            mant_q   <= 24'h0;
            exp_q    <= 9'h0;
            sign_q   <= 1'b0;
            carry_q  <= 1'b0;
            result_q <= 32'h0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed by the combinational block.
            state_q  <= state_d;
            mant_q   <= mant_d;
            exp_q    <= exp_d;
            sign_q   <= sign_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

endmodule
